// File: rtl/weight_stream_packer_if.sv
// Lane-packed weight byte stream (valid/ready) between the DMA/loader and the packer.
// Master drives data/valid/last, slave returns ready.
interface weight_stream_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_BYTES   = 8
);
  logic [IN_BYTES*DATA_WIDTH-1:0] s_data;
  logic                           s_valid;
  logic                           s_ready;
  logic                           s_last;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/weight_stream_packer.sv
// Assembles a lane-packed byte stream into Wh x Ww weight words for the PE weight buffer.
// Optional framing check on s_last is enabled by defining WSP_ERR_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start, stream not accepted
// FILL  | accepting beats of the current word
// WRITE | word complete, strobing wren once the buffer is not full
// DONE  | one-cycle completion pulse, then back to IDLE
module weight_stream_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int Wh         = 2,
  parameter int Ww         = 29,
  parameter int IN_BYTES   = 8,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CNT_W-1:0]               num_words,
  output logic                           busy,
  output logic                           done,
  weight_stream_packer_if.slave          s,
  output logic [Wh*Ww*DATA_WIDTH-1:0]    weight_buffer_din,
  output logic                           weight_buffer_wren,
  input  logic                           weight_buffer_full,
  output logic                           err
);

  localparam int TOTAL  = Wh * Ww;
  localparam int BEATS  = (TOTAL + IN_BYTES - 1) / IN_BYTES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                       state, next_state;
  logic [BEAT_W-1:0]            beat_cnt;
  logic [CNT_W-1:0]             word_cnt;
  logic [CNT_W-1:0]             num_words_q;
  logic [TOTAL*DATA_WIDTH-1:0]  din_q, din_next;
  logic                         load_start;
  logic                         hs;
  logic                         last_word;

  assign last_word = (word_cnt == num_words_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state         = state;
    busy               = 1'b0;
    done               = 1'b0;
    s.s_ready          = 1'b0;
    weight_buffer_wren = 1'b0;
    load_start         = 1'b0;
    hs                 = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_start = 1'b1;
          next_state = (num_words == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        busy      = 1'b1;
        s.s_ready = 1'b1;
        if (s.s_valid) begin
          hs = 1'b1;
          if (beat_cnt == LAST_BEAT) next_state = WRITE;
        end
      end
      WRITE: begin
        busy = 1'b1;
        if (!weight_buffer_full) begin
          weight_buffer_wren = 1'b1;
          next_state         = last_word ? DONE : FILL;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Every element position maps to exactly one (beat, lane); lanes past TOTAL on the
  // final beat have no position and are dropped. Untouched positions keep old values.
  always_comb begin
    din_next = din_q;
    for (int i = 0; i < TOTAL; i++) begin
      if (beat_cnt == BEAT_W'(i / IN_BYTES))
        din_next[i*DATA_WIDTH +: DATA_WIDTH] = s.s_data[(i % IN_BYTES)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt    <= '0;
      word_cnt    <= '0;
      num_words_q <= '0;
      din_q       <= '0;
    end else begin
      if (load_start) begin
        num_words_q <= num_words;
        beat_cnt    <= '0;
        word_cnt    <= '0;
      end
      if (hs) begin
        din_q    <= din_next;
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
      end
      if (weight_buffer_wren) word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  assign weight_buffer_din = din_q;

`ifdef WSP_ERR_CHECK_EN
  logic err_q;
  logic final_beat;

  // s_last must coincide exactly with the last beat of the last word.
  assign final_beat = (beat_cnt == LAST_BEAT) && last_word;

  always_ff @(posedge clk) begin
    if (rst)                              err_q <= 1'b0;
    else if (hs && (s.s_last != final_beat)) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_last;
  assign unused_last = s.s_last;
  assign err         = 1'b0;
`endif

endmodule
